// File: rtl/pulse_pkg.sv
// Shared width default and FSM state encoding for the pulse period meter.
package pulse_pkg;

  localparam int unsigned CNT_W_DEF = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

endpackage

// File: rtl/pulse_edge_det.sv
// Rising-edge detector on the comparator output; ad_pulse is already ad_clk-synchronous.
module pulse_edge_det (
  input  logic ad_clk,
  input  logic rst_n,
  input  logic ad_pulse,
  output logic rise
);

  logic pulse_d;

  always_ff @(posedge ad_clk) begin
    if (!rst_n) begin
      pulse_d <= 1'b0;
    end else begin
      pulse_d <= ad_pulse;
    end
  end

  assign rise = ad_pulse & ~pulse_d;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures period and high time of ad_pulse between consecutive rising edges,
// presenting each result through a valid/ready register with sticky overrun/timeout flags.
module pulse_period_meter
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             ad_clk,
  input  logic             rst_n,
  input  logic             ad_pulse,
  input  logic             clear,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             rise;
  state_t           state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;

  pulse_edge_det u_edge_det (
    .ad_clk   (ad_clk),
    .rst_n    (rst_n),
    .ad_pulse (ad_pulse),
    .rise     (rise)
  );

  // Measurement FSM; counters restart at 1 on each edge because the edge cycle itself is high.
  always_ff @(posedge ad_clk) begin
    if (!rst_n || clear) begin
      state      <= ST_IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (rise) begin
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
            state      <= ST_MEAS;
          end else begin
            period_cnt <= '0;
            high_cnt   <= '0;
          end
        end
        ST_MEAS: begin
          if (rise) begin
            period     <= period_cnt;
            high_time  <= high_cnt;
            meas_valid <= 1'b1;
            if (meas_valid && !meas_ready) begin
              overrun <= 1'b1;
            end
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
          end else if (period_cnt == CNT_MAX) begin
            // Saturated without an edge: abandon the measurement, keep old results.
            state      <= ST_IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            timeout    <= 1'b1;
          end else begin
            period_cnt <= period_cnt + CNT_ONE;
            if (ad_pulse) begin
              high_cnt <= high_cnt + CNT_ONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Randomized and directed bench for pulse_period_meter with a queue-based scoreboard.
module tb_pulse_period_meter;

  localparam int unsigned W = 8;
  localparam int MAX_CNT = 255;

  logic         ad_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ad_pulse = 1'b0;
  logic         clear = 1'b0;
  logic         meas_ready = 1'b0;
  logic         meas_valid;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         overrun;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int p;
    int h;
  } res_t;

  res_t exp_q[$];
  res_t e;

  // Reference model state: time of last arming edge and high cycles accumulated since.
  int cyc = 0;
  int arm_cyc = 0;
  int highs = 0;
  bit prev = 1'b0;
  bit armed = 1'b0;
  bit rise_m = 1'b0;
  bit valid_m = 1'b0;
  bit ovr_m = 1'b0;
  bit to_m = 1'b0;
  bit chk_en = 1'b0;

  pulse_period_meter #(.CNT_W(W)) dut (
    .ad_clk     (ad_clk),
    .rst_n      (rst_n),
    .ad_pulse   (ad_pulse),
    .clear      (clear),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .period     (period),
    .high_time  (high_time),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 ad_clk = ~ad_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Behavioural model: period = cycles between rising edges, high = high cycles in that span.
  always @(posedge ad_clk) begin
    cyc++;
    if (!rst_n) begin
      prev = 1'b0; armed = 1'b0; valid_m = 1'b0; ovr_m = 1'b0; to_m = 1'b0;
      exp_q.delete();
    end else begin
      rise_m = ad_pulse && !prev;
      prev = ad_pulse;
      if (clear) begin
        armed = 1'b0; valid_m = 1'b0; ovr_m = 1'b0; to_m = 1'b0;
        exp_q.delete();
      end else begin
        if (valid_m && meas_ready) valid_m = 1'b0;
        if (rise_m) begin
          if (armed) begin
            if (valid_m) begin
              ovr_m = 1'b1;
              if (exp_q.size() > 0) void'(exp_q.pop_back());
            end
            exp_q.push_back('{cyc - arm_cyc, highs});
            valid_m = 1'b1;
          end
          armed = 1'b1;
          arm_cyc = cyc;
          highs = 1;
        end else if (armed) begin
          if (cyc - arm_cyc == MAX_CNT) begin
            armed = 1'b0;
            to_m = 1'b1;
          end else begin
            highs += int'(ad_pulse);
          end
        end
      end
    end
  end

  // Monitor: flags every cycle, result payload whenever a handshake is about to complete.
  always @(negedge ad_clk) begin
    if (chk_en) begin
      check("meas_valid", 32'(meas_valid), 32'(valid_m));
      check("overrun", 32'(overrun), 32'(ovr_m));
      check("timeout", 32'(timeout), 32'(to_m));
      if (meas_valid === 1'b1 && meas_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result: DUT presented period %0d with no expected result at cycle %0d",
                   period, cyc);
        end else begin
          e = exp_q.pop_front();
          check("period", 32'(period), 32'(e.p));
          check("high_time", 32'(high_time), 32'(e.h));
        end
      end
    end
  end

  task automatic tick(input logic p, input logic rdy, input logic clr);
    ad_pulse = p;
    meas_ready = rdy;
    clear = clr;
    @(posedge ad_clk);
    #1;
  endtask

  task automatic pulses(input int hi, input int lo, input int n, input logic rdy);
    repeat (n) begin
      repeat (hi) tick(1'b1, rdy, 1'b0);
      repeat (lo) tick(1'b0, rdy, 1'b0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_high_time"}, 32'(high_time), 32'd0);
    check({tag, "_valid"}, 32'(meas_valid), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    int hi;
    int lo;
    logic rr;
    logic cl;

    rst_n = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    check_zero("reset");
    rst_n = 1'b1;

    // 3 high / 5 low with ready: period 8, high 3.
    pulses(3, 5, 6, 1'b1);
    check("p35_overrun", 32'(overrun), 32'd0);
    tick(1'b0, 1'b1, 1'b1);

    // Toggle every cycle: period 2, high 1.
    for (int i = 0; i < 12; i++) tick(logic'(i % 2 == 0), 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);

    // Single edge then silence: saturation timeout, no result.
    tick(1'b1, 1'b1, 1'b0);
    repeat (MAX_CNT + 5) tick(1'b0, 1'b1, 1'b0);
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_valid", 32'(meas_valid), 32'd0);
    tick(1'b0, 1'b1, 1'b1);
    check("to_cleared", 32'(timeout), 32'd0);

    // Consumer stalled over three 4/4 periods: overwrite sets overrun.
    pulses(4, 4, 3, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("ovr_valid", 32'(meas_valid), 32'd1);
    check("ovr_period", 32'(period), 32'd8);
    check("ovr_high", 32'(high_time), 32'd4);
    check("ovr_flag", 32'(overrun), 32'd1);
    tick(1'b0, 1'b1, 1'b0);
    check("ovr_drained", 32'(meas_valid), 32'd0);
    tick(1'b0, 1'b1, 1'b1);

    // Reset mid-period, then 2/2 pulses: first edge only arms.
    pulses(2, 2, 2, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    check("rst_arm_only", 32'(meas_valid), 32'd0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("rst_valid", 32'(meas_valid), 32'd1);
    check("rst_period", 32'(period), 32'd4);
    check("rst_high", 32'(high_time), 32'd2);
    pulses(2, 2, 3, 1'b1);

    // Clear coincident with a rising edge, pending result and overrun present.
    pulses(2, 2, 3, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    check_zero("clr_rise");
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("clr_arm_only", 32'(meas_valid), 32'd0);
    pulses(3, 3, 3, 1'b1);

    // Randomized pulse trains with random backpressure, occasional clears and timeouts.
    for (int it = 0; it < 150; it++) begin
      hi = int'($urandom_range(1, 12));
      lo = ($urandom_range(0, 19) == 0) ? MAX_CNT + 10 : int'($urandom_range(1, 12));
      for (int k = 0; k < hi + lo; k++) begin
        rr = ($urandom_range(0, 3) != 0);
        cl = ($urandom_range(0, 299) == 0);
        tick(logic'(k < hi), rr, cl);
      end
    end
    repeat (4) tick(1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 SHALL have parameter: CNT_W, 24, width of period/high-time counters and results.
REQ-002 SHALL have port: ad_clk  input  1  AD sample clock, the only clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: ad_pulse  input  1  hysteresis comparator output, synchronous to ad_clk.
REQ-005 SHALL have port: clear  input  1  synchronous soft clear, active-high.
REQ-006 SHALL have port: meas_ready  input  1  consumer accepts current result.
REQ-007 SHALL have port: meas_valid  output  1  result registers hold an unconsumed measurement.
REQ-008 SHALL have port: period  output  CNT_W  ad_clk cycles between consecutive rising edges.
REQ-009 SHALL have port: high_time  output  CNT_W  ad_clk cycles ad_pulse was 1 within that period.
REQ-010 SHALL have port: overrun  output  1  sticky; an unconsumed result was overwritten.
REQ-011 SHALL have port: timeout  output  1  sticky; counter saturated without a rising edge.

Function
REQ-012 SHALL register ad_pulse once (pulse_d); rise = ad_pulse & ~pulse_d.
REQ-013 SHALL implement FSM states IDLE and MEAS; reset/clear enter IDLE.
REQ-014 IDLE: on rise SHALL load period_cnt=1, high_cnt=1 and go to MEAS; otherwise hold counters at 0.
REQ-015 MEAS, no rise: period_cnt +1; high_cnt +1 when ad_pulse=1.
REQ-016 MEAS, rise: SHALL load period<=period_cnt, high_time<=high_cnt, meas_valid<=1, reload counters to 1, stay in MEAS.
REQ-017 Results SHALL appear the cycle after the ad_clk edge that samples rise (1-cycle latency).
REQ-018 meas_valid SHALL stay 1 until sampled with meas_ready=1, then clear next cycle unless REQ-019 applies.
REQ-019 New result and meas_ready=1 in the same cycle: meas_valid stays 1 with new data; overrun unchanged.
REQ-020 New result while meas_valid=1 and meas_ready=0: data overwritten, overrun<=1.
REQ-021 MEAS, period_cnt all-ones and no rise: SHALL go to IDLE, counters to 0, timeout<=1, results untouched.
REQ-022 Counters SHALL never wrap; high_cnt <= period_cnt always holds.
REQ-023 clear SHALL zero period, high_time, meas_valid, overrun, timeout and counters, and force IDLE; clear has priority over rise.

Reset
REQ-024 rst_n=0 at an ad_clk edge SHALL set all outputs, counters and pulse_d to 0 and state to IDLE.
REQ-025 Reset mid-measurement SHALL discard the partial count; the first rise after release only arms (IDLE->MEAS).

Structure
REQ-026 Package pulse_pkg SHALL hold the CNT_W default and FSM state encoding.
REQ-027 Edge detection SHALL be a sub-module pulse_edge_det (input ad_pulse, output rise).
REQ-028 Implementation SHALL be fully synchronous, no latches, no derived clocks.

Verification
REQ-029 ad_pulse 3 high / 5 low repeated, meas_ready=1 -> period=8, high_time=3 from second rise onward, overrun=0.
REQ-030 ad_pulse toggling every cycle -> period=2, high_time=1 each result.
REQ-031 CNT_W=8, one rise then ad_pulse held 0 -> timeout=1 within 256 cycles of rise, meas_valid never 1.
REQ-032 meas_ready=0, 3 periods of 4/4 -> meas_valid=1, period=8, overrun=1; ready pulse clears meas_valid.
REQ-033 rst_n=0 for one cycle mid-period, then 2/2 pulses -> first result after second post-reset rise, period=4, high_time=2.
REQ-034 clear asserted with rise in same cycle -> all outputs 0, state IDLE, next rise arms only.
